// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues in-order word fetches under a credit
// limit, buffers returned words with their PCs, and flushes on redirect while
// dropping stale in-flight responses.
module instr_prefetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    output logic                         mem_req_o,
    output logic [ADDR_W-1:0]            mem_addr_o,
    input  logic                         mem_gnt_i,
    input  logic                         mem_rvalid_i,
    input  logic [DATA_W-1:0]            mem_rdata_i,
    input  logic                         redirect_i,
    input  logic [ADDR_W-1:0]            redirect_pc_i,
    input  logic                         fetch_ready_i,
    output logic                         fetch_valid_o,
    output logic [DATA_W-1:0]            fetch_instr_o,
    output logic [ADDR_W-1:0]            fetch_pc_o,
    output logic [ADDR_W-1:0]            fetch_pc4_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {FETCH, DRAIN} state_e;

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        pc_q, pc_d;
    logic [CNT_W-1:0]         occ_q, occ_d;
    logic [CNT_W-1:0]         out_q, out_d;
    logic [CNT_W-1:0]         disc_q, disc_d;
    logic [PTR_W-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PTR_W-1:0]         sh_wptr_q, sh_wptr_d, sh_rptr_q, sh_rptr_d;

    logic [DATA_W-1:0]        instr_q  [DEPTH];
    logic [ADDR_W-1:0]        pcbuf_q  [DEPTH];
    logic [ADDR_W-1:0]        shadow_q [DEPTH];

    logic                     credit, issue, drop, push, pop;

    // Handshake decode: credit check, issue, drop/push of responses, pop
    always_comb begin
        credit        = ({1'b0, occ_q} + {1'b0, out_q}) < (CNT_W+1)'(DEPTH);
        mem_req_o     = credit && !redirect_i && rst_i;
        mem_addr_o    = pc_q;
        issue         = mem_req_o && mem_gnt_i;
        drop          = mem_rvalid_i && (redirect_i || state_q == DRAIN);
        push          = mem_rvalid_i && !drop;
        fetch_valid_o = (occ_q != '0) && rst_i;
        pop           = fetch_valid_o && fetch_ready_i;
        occupancy_o   = occ_q;
        fetch_instr_o = fetch_valid_o ? instr_q[rptr_q] : '0;
        fetch_pc_o    = fetch_valid_o ? pcbuf_q[rptr_q] : '0;
        fetch_pc4_o   = fetch_valid_o ? pcbuf_q[rptr_q] + ADDR_W'(4) : '0;
    end

    // Next-state for PC, counters, pointers and FSM; redirect has priority
    always_comb begin
        pc_d      = pc_q;
        occ_d     = occ_q;
        out_d     = out_q + CNT_W'(issue) - CNT_W'(mem_rvalid_i);
        disc_d    = disc_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        // The shadow queue tracks every outstanding request, stale or not,
        // so it advances on every response and is never flushed by redirect.
        sh_wptr_d = sh_wptr_q + PTR_W'(issue);
        sh_rptr_d = sh_rptr_q + PTR_W'(mem_rvalid_i);
        if (redirect_i) begin
            pc_d   = redirect_pc_i & ~ADDR_W'(3);
            occ_d  = '0;
            wptr_d = '0;
            rptr_d = '0;
            disc_d = out_q - CNT_W'(mem_rvalid_i);
        end else begin
            if (issue)
                pc_d = pc_q + ADDR_W'(4);
            if (mem_rvalid_i && state_q == DRAIN)
                disc_d = disc_q - CNT_W'(1);
            occ_d  = occ_q + CNT_W'(push) - CNT_W'(pop);
            wptr_d = wptr_q + PTR_W'(push);
            rptr_d = rptr_q + PTR_W'(pop);
        end
        state_d = (disc_d != '0) ? DRAIN : FETCH;
    end

    // Control state registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            occ_q     <= '0;
            out_q     <= '0;
            disc_q    <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            sh_wptr_q <= '0;
            sh_rptr_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            occ_q     <= occ_d;
            out_q     <= out_d;
            disc_q    <= disc_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            sh_wptr_q <= sh_wptr_d;
            sh_rptr_q <= sh_rptr_d;
        end
    end

    // Storage arrays: PC shadow written at grant, FIFO written on kept response
    always_ff @(posedge clk_i) begin
        if (issue)
            shadow_q[sh_wptr_q] <= pc_q;
        if (push) begin
            instr_q[wptr_q] <= mem_rdata_i;
            pcbuf_q[wptr_q] <= shadow_q[sh_rptr_q];
        end
    end

    // A kept response into a full FIFO means the memory broke the credit rule
    always_ff @(posedge clk_i) begin
        if (rst_i)
            assert (!(push && occ_q == CNT_W'(DEPTH) && !pop));
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: memory handshake driven by hand,
// expected values computed per step.
module tb_instr_prefetch_queue;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        fetch_ready_i;
    logic        fetch_valid_o;
    logic [31:0] fetch_instr_o;
    logic [31:0] fetch_pc_o;
    logic [31:0] fetch_pc4_o;
    logic [2:0]  occupancy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    instr_prefetch_queue #(
        .DEPTH(4), .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .fetch_ready_i(fetch_ready_i), .fetch_valid_o(fetch_valid_o),
        .fetch_instr_o(fetch_instr_o), .fetch_pc_o(fetch_pc_o),
        .fetch_pc4_o(fetch_pc4_o), .occupancy_o(occupancy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; checks follow 1ns later
    task automatic drive(input logic rst, input logic gnt, input logic rv,
                         input logic [31:0] rd, input logic rdy,
                         input logic rdr, input logic [31:0] rpc);
        @(negedge clk_i);
        rst_i = rst; mem_gnt_i = gnt; mem_rvalid_i = rv; mem_rdata_i = rd;
        fetch_ready_i = rdy; redirect_i = rdr; redirect_pc_i = rpc;
        #1;
    endtask

    initial begin
        rst_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        fetch_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;

        // 1. reset, then streaming with ready=1
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rst_req", mem_req_o, 0);
        chk("rst_valid", fetch_valid_o, 0);
        chk("rst_occ", occupancy_o, 0);
        chk("rst_addr", mem_addr_o, 32'h0);
        drive(0, 1, 0, 0, 1, 0, 0);
        chk("rst_req_gnt", mem_req_o, 0);
        drive(1, 1, 0, 0, 1, 0, 0);
        chk("a1_req", mem_req_o, 1);
        chk("a1_addr", mem_addr_o, 32'h0);
        drive(1, 1, 1, 32'h1000_0013, 1, 0, 0);
        chk("a2_addr", mem_addr_o, 32'h4);
        chk("a2_valid", fetch_valid_o, 0);
        drive(1, 1, 1, 32'h1111_0013, 1, 0, 0);
        chk("a3_valid", fetch_valid_o, 1);
        chk("a3_pc", fetch_pc_o, 32'h0);
        chk("a3_pc4", fetch_pc4_o, 32'h4);
        chk("a3_instr", fetch_instr_o, 32'h1000_0013);
        chk("a3_addr", mem_addr_o, 32'h8);
        drive(1, 1, 1, 32'h1222_0013, 1, 0, 0);
        chk("a4_pc", fetch_pc_o, 32'h4);
        chk("a4_pc4", fetch_pc4_o, 32'h8);
        chk("a4_instr", fetch_instr_o, 32'h1111_0013);
        chk("a4_addr", mem_addr_o, 32'hC);
        drive(1, 0, 1, 32'h1333_0013, 1, 0, 0);
        chk("a5_pc", fetch_pc_o, 32'h8);
        chk("a5_pc4", fetch_pc4_o, 32'hC);
        chk("a5_addr", mem_addr_o, 32'h10);
        drive(1, 0, 0, 0, 1, 0, 0);
        chk("a6_pc", fetch_pc_o, 32'hC);
        chk("a6_instr", fetch_instr_o, 32'h1333_0013);
        chk("a6_occ", occupancy_o, 1);
        drive(1, 0, 0, 0, 1, 0, 0);
        chk("a7_valid", fetch_valid_o, 0);
        chk("a7_instr_zero", fetch_instr_o, 0);
        chk("a7_pc_zero", fetch_pc_o, 0);
        chk("a7_pc4_zero", fetch_pc4_o, 0);
        chk("a7_occ", occupancy_o, 0);

        // 2. stalled consumer, always-granting memory: credit limit
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("b1_req", mem_req_o, 1);
        chk("b1_addr", mem_addr_o, 32'h10);
        drive(1, 1, 1, 32'hE000_0000, 0, 0, 0);
        chk("b2_req", mem_req_o, 1);
        drive(1, 1, 1, 32'hE000_0001, 0, 0, 0);
        chk("b3_req", mem_req_o, 1);
        drive(1, 1, 1, 32'hE000_0002, 0, 0, 0);
        chk("b4_req", mem_req_o, 1);
        chk("b4_addr", mem_addr_o, 32'h1C);
        drive(1, 1, 1, 32'hE000_0003, 0, 0, 0);
        chk("b5_req_nocredit", mem_req_o, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("b6_occ_full", occupancy_o, 4);
        chk("b6_req", mem_req_o, 0);
        chk("b6_pc", fetch_pc_o, 32'h10);
        drive(1, 1, 0, 0, 1, 0, 0);
        chk("b7_req_full", mem_req_o, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("b8_req_after_pop", mem_req_o, 1);
        chk("b8_addr", mem_addr_o, 32'h20);
        chk("b8_occ", occupancy_o, 3);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("b9_req", mem_req_o, 0);
        chk("b9_pc", fetch_pc_o, 32'h14);
        drive(1, 0, 1, 32'hE000_0004, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 0);
        chk("b11_occ", occupancy_o, 4);
        chk("b11_pc", fetch_pc_o, 32'h14);
        drive(1, 0, 0, 0, 1, 0, 0);
        chk("b12_pc", fetch_pc_o, 32'h18);
        drive(1, 0, 0, 0, 1, 0, 0);
        chk("b13_pc", fetch_pc_o, 32'h1C);
        drive(1, 0, 0, 0, 1, 0, 0);
        chk("b14_pc", fetch_pc_o, 32'h20);
        chk("b14_instr", fetch_instr_o, 32'hE000_0004);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("b15_valid", fetch_valid_o, 0);

        // 3. three outstanding, redirect to 0x103
        drive(1, 1, 0, 0, 1, 0, 0);
        chk("c1_addr", mem_addr_o, 32'h24);
        drive(1, 1, 0, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 1, 0, 0);
        chk("c3_addr", mem_addr_o, 32'h2C);
        drive(1, 1, 0, 0, 1, 1, 32'h103);
        chk("c4_req_redirect", mem_req_o, 0);
        drive(1, 0, 1, 32'hDEAD_0001, 1, 0, 0);
        chk("c5_addr", mem_addr_o, 32'h100);
        chk("c5_req_drain", mem_req_o, 1);
        drive(1, 0, 1, 32'hDEAD_0002, 1, 0, 0);
        chk("c6_valid", fetch_valid_o, 0);
        drive(1, 0, 1, 32'hDEAD_0003, 1, 0, 0);
        chk("c7_valid", fetch_valid_o, 0);
        drive(1, 1, 0, 0, 1, 0, 0);
        chk("c8_valid", fetch_valid_o, 0);
        chk("c8_occ", occupancy_o, 0);
        chk("c8_addr", mem_addr_o, 32'h100);
        drive(1, 0, 1, 32'hF000_0000, 1, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 0);
        chk("c10_valid", fetch_valid_o, 1);
        chk("c10_pc", fetch_pc_o, 32'h100);
        chk("c10_instr", fetch_instr_o, 32'hF000_0000);

        // 4. redirect coinciding with rvalid, two outstanding
        drive(1, 1, 0, 0, 1, 0, 0);
        chk("d1_addr", mem_addr_o, 32'h104);
        drive(1, 1, 0, 0, 1, 0, 0);
        drive(1, 1, 1, 32'hDEAD_0004, 1, 1, 32'h300);
        chk("d3_req_redirect", mem_req_o, 0);
        drive(1, 0, 0, 0, 1, 0, 0);
        chk("d4_valid", fetch_valid_o, 0);
        chk("d4_occ", occupancy_o, 0);
        chk("d4_addr", mem_addr_o, 32'h300);
        drive(1, 0, 1, 32'hDEAD_0005, 1, 0, 0);
        drive(1, 1, 0, 0, 1, 0, 0);
        chk("d6_valid", fetch_valid_o, 0);
        chk("d6_req", mem_req_o, 1);
        drive(1, 0, 1, 32'hC000_0000, 1, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 0);
        chk("d8_valid", fetch_valid_o, 1);
        chk("d8_pc", fetch_pc_o, 32'h300);
        chk("d8_instr", fetch_instr_o, 32'hC000_0000);

        // 5. second redirect while draining: 1 stale + 1 new-stream outstanding
        drive(1, 1, 0, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 1, 0, 0);
        drive(1, 0, 1, 32'hDEAD_0006, 1, 1, 32'h400);
        drive(1, 1, 0, 0, 1, 0, 0);
        chk("e4_req_drain", mem_req_o, 1);
        chk("e4_addr", mem_addr_o, 32'h400);
        drive(1, 1, 0, 0, 1, 1, 32'h200);
        chk("e5_req_redirect", mem_req_o, 0);
        drive(1, 0, 1, 32'hDEAD_0007, 1, 0, 0);
        chk("e6_addr", mem_addr_o, 32'h200);
        chk("e6_valid", fetch_valid_o, 0);
        drive(1, 1, 1, 32'hDEAD_0008, 1, 0, 0);
        chk("e7_valid", fetch_valid_o, 0);
        chk("e7_req", mem_req_o, 1);
        drive(1, 0, 1, 32'hAB00_0000, 1, 0, 0);
        chk("e8_valid", fetch_valid_o, 0);
        chk("e8_occ", occupancy_o, 0);
        drive(1, 0, 0, 0, 1, 0, 0);
        chk("e9_valid", fetch_valid_o, 1);
        chk("e9_pc", fetch_pc_o, 32'h200);
        chk("e9_instr", fetch_instr_o, 32'hAB00_0000);

        // 6. address wrap at top of memory, then reset mid-stream
        drive(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("f2_addr", mem_addr_o, 32'hFFFF_FFFC);
        chk("f2_req", mem_req_o, 1);
        drive(1, 0, 1, 32'h5A5A_5A5A, 0, 0, 0);
        chk("f3_addr_wrap", mem_addr_o, 32'h0);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("f4_valid", fetch_valid_o, 1);
        chk("f4_pc", fetch_pc_o, 32'hFFFF_FFFC);
        chk("f4_pc4_wrap", fetch_pc4_o, 32'h0);
        chk("f4_instr", fetch_instr_o, 32'h5A5A_5A5A);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("f5_req_rstlow", mem_req_o, 0);
        chk("f5_valid_rstlow", fetch_valid_o, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("f6_occ", occupancy_o, 0);
        chk("f6_addr", mem_addr_o, 32'h0);
        chk("f6_valid", fetch_valid_o, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("f7_req", mem_req_o, 1);
        chk("f7_addr", mem_addr_o, 32'h0);
        chk("f7_valid", fetch_valid_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
